// File: rtl/multdiv_ctrl.sv
// Iterative 32-bit signed multiply/divide unit beside the X-stage ALU.
// Stalls the pipeline for 33 cycles and presents the result with a writeback-format word.
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_instruction,
    input  logic [31:0] x_opA,
    input  logic [31:0] x_opB,
    input  logic        flush,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result_data,
    output logic [4:0]  result_reg,
    output logic [31:0] wb_instruction
);

    localparam logic [4:0]  OpAlu         = 5'b00000;
    localparam logic [4:0]  FuncMul       = 5'b00110;
    localparam logic [4:0]  FuncDiv       = 5'b00111;
    localparam logic [4:0]  OpSetx        = 5'b10101;
    localparam logic [4:0]  ExcReg        = 5'd30;
    localparam logic [26:0] StatusMulOvf  = 27'd4;
    localparam logic [26:0] StatusDivZero = 27'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        div_zero_q, div_zero_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] instr_q, instr_d;
    // mul: opa = shifting multiplicand, opb = shifting multiplier, acc = product.
    // div: opa[31:0] = dividend shifting into quotient, opb = divisor, acc[31:0] = remainder.
    logic [63:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] res_data_q, res_data_d;
    logic [4:0]  res_reg_q, res_reg_d;
    logic [31:0] wb_instr_q, wb_instr_d;

    logic        start;
    logic [63:0] mul_acc_nxt;
    logic [63:0] mul_opa_nxt;
    logic [31:0] mul_opb_nxt;
    logic [32:0] div_rem_shift;
    logic [32:0] div_diff;
    logic [31:0] div_rem_nxt;
    logic [31:0] div_quo_nxt;
    logic [63:0] mul_signed;
    logic [32:0] mul_hi;
    logic        mul_ovf;
    logic [31:0] div_signed;

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign start = (x_instruction[31:27] == OpAlu) &&
                   ((x_instruction[6:2] == FuncMul) || (x_instruction[6:2] == FuncDiv));

    // Datapath step for the current RUN cycle.
    always_comb begin
        mul_acc_nxt = opb_q[0] ? (acc_q + opa_q) : acc_q;
        mul_opa_nxt = {opa_q[62:0], 1'b0};
        mul_opb_nxt = {1'b0, opb_q[31:1]};

        div_rem_shift = {acc_q[31:0], opa_q[31]};
        div_diff      = div_rem_shift - {1'b0, opb_q};
        if (!div_diff[32]) begin
            div_rem_nxt = div_diff[31:0];
            div_quo_nxt = {opa_q[30:0], 1'b1};
        end else begin
            div_rem_nxt = div_rem_shift[31:0];
            div_quo_nxt = {opa_q[30:0], 1'b0};
        end

        mul_signed = neg_q ? (~mul_acc_nxt + 64'd1) : mul_acc_nxt;
        mul_hi     = mul_signed[63:31];
        mul_ovf    = !((&mul_hi) || !(|mul_hi));
        div_signed = neg_q ? (~div_quo_nxt + 32'd1) : div_quo_nxt;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        rd_d       = rd_q;
        instr_d    = instr_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        res_data_d = res_data_q;
        res_reg_d  = res_reg_q;
        wb_instr_d = wb_instr_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d    = StRun;
                    count_d    = 5'd0;
                    is_div_d   = (x_instruction[6:2] == FuncDiv);
                    neg_d      = x_opA[31] ^ x_opB[31];
                    div_zero_d = (x_opB == 32'd0);
                    rd_d       = x_instruction[26:22];
                    instr_d    = x_instruction;
                    opa_d      = {32'd0, magnitude(x_opA)};
                    opb_d      = magnitude(x_opB);
                    acc_d      = 64'd0;
                end
            end
            StRun: begin
                if (!is_div_q) begin
                    acc_d = mul_acc_nxt;
                    opa_d = mul_opa_nxt;
                    opb_d = mul_opb_nxt;
                end else if (!div_zero_q) begin
                    acc_d = {32'd0, div_rem_nxt};
                    opa_d = {32'd0, div_quo_nxt};
                end
                // A zero divisor leaves the datapath idle but still burns all 32 cycles.

                if (flush) begin
                    state_d = StIdle;
                end else if (count_q == 5'd31) begin
                    state_d = StDone;
                    if (is_div_q && div_zero_q) begin
                        res_data_d = {5'd0, StatusDivZero};
                        res_reg_d  = ExcReg;
                        wb_instr_d = {OpSetx, StatusDivZero};
                    end else if (!is_div_q && mul_ovf) begin
                        res_data_d = {5'd0, StatusMulOvf};
                        res_reg_d  = ExcReg;
                        wb_instr_d = {OpSetx, StatusMulOvf};
                    end else begin
                        res_data_d = is_div_q ? div_signed : mul_signed[31:0];
                        res_reg_d  = rd_q;
                        wb_instr_d = instr_q;
                    end
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            StDone: begin
                // The finished instruction is still in X, so start is ignored here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= 5'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            rd_q       <= 5'd0;
            instr_q    <= 32'd0;
            opa_q      <= 64'd0;
            opb_q      <= 32'd0;
            acc_q      <= 64'd0;
            res_data_q <= 32'd0;
            res_reg_q  <= 5'd0;
            wb_instr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            rd_q       <= rd_d;
            instr_q    <= instr_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            res_data_q <= res_data_d;
            res_reg_q  <= res_reg_d;
            wb_instr_q <= wb_instr_d;
        end
    end

    assign busy           = ((state_q == StIdle) && start && !flush) || (state_q == StRun);
    assign result_ready   = (state_q == StDone);
    assign result_data    = res_data_q;
    assign result_reg     = res_reg_q;
    assign wb_instruction = wb_instr_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: latency, signed results, exceptions, flush and reset.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] x_instruction;
    logic [31:0] x_opA;
    logic [31:0] x_opB;
    logic        flush;
    logic        busy;
    logic        result_ready;
    logic [31:0] result_data;
    logic [4:0]  result_reg;
    logic [31:0] wb_instruction;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;
    logic        bad;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .x_instruction  (x_instruction),
        .x_opA          (x_opA),
        .x_opB          (x_opB),
        .flush          (flush),
        .busy           (busy),
        .result_ready   (result_ready),
        .result_data    (result_data),
        .result_reg     (result_reg),
        .wb_instruction (wb_instruction)
    );

    function automatic logic [31:0] mk_md(input logic [4:0] rd, input logic is_div);
        logic [4:0] func;
        func = is_div ? 5'b00111 : 5'b00110;
        return {5'b00000, rd, 15'd0, func, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives an op in the accept cycle and checks busy for cycles 0..32 and the result at 33.
    task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data,
                          input logic [4:0] exp_reg, input logic [31:0] exp_wb);
        x_instruction = instr;
        x_opA         = a;
        x_opB         = b;
        flush         = 1'b0;
        #1;
        check({tag, " accept busy"}, 32'(busy), 32'd1);
        bad = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (busy !== 1'b1 || result_ready !== 1'b0) bad = 1'b1;
        end
        check({tag, " run busy/ready"}, 32'(bad), 32'd0);
        tick();
        check({tag, " done ready"}, 32'(result_ready), 32'd1);
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " data"}, result_data, exp_data);
        check({tag, " reg"}, 32'(result_reg), 32'(exp_reg));
        check({tag, " wb"}, wb_instruction, exp_wb);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        x_instruction = 32'd0;
        x_opA         = 32'd0;
        x_opB         = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset ready", 32'(result_ready), 32'd0);
        check("reset data", result_data, 32'd0);
        check("reset reg", 32'(result_reg), 32'd0);
        check("reset wb", wb_instruction, 32'd0);
        tick();

        // mul held in X through DONE, then an addi follows.
        run_op("mul 7*-6", mk_md(5'd3, 1'b0), 32'd7, 32'hFFFF_FFFA,
               32'hFFFF_FFD6, 5'd3, mk_md(5'd3, 1'b0));
        tick();
        x_instruction = {5'b00101, 5'd4, 22'd1};
        #1;
        check("addi busy", 32'(busy), 32'd0);
        check("after done ready", 32'(result_ready), 32'd0);
        tick();
        check("addi busy 2", 32'(busy), 32'd0);
        check("hold data", result_data, 32'hFFFF_FFD6);
        check("hold reg", 32'(result_reg), 32'd3);
        tick();

        // Three back-to-back divides: accepts at 0, 34, 68.
        run_op("div -17/5", mk_md(5'd9, 1'b1), 32'hFFFF_FFEF, 32'd5,
               32'hFFFF_FFFD, 5'd9, mk_md(5'd9, 1'b1));
        tick();
        run_op("div min/-1", mk_md(5'd12, 1'b1), 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 5'd12, mk_md(5'd12, 1'b1));
        tick();
        run_op("div 100/-7", mk_md(5'd1, 1'b1), 32'd100, 32'hFFFF_FFF9,
               32'hFFFF_FFF2, 5'd1, mk_md(5'd1, 1'b1));
        tick();

        // Exceptions.
        run_op("mul ovf", mk_md(5'd5, 1'b0), 32'h0001_0000, 32'h0001_0000,
               32'd4, 5'd30, 32'hA800_0004);
        tick();
        run_op("div by 0", mk_md(5'd6, 1'b1), 32'd12, 32'd0,
               32'd5, 5'd30, 32'hA800_0005);
        tick();

        // Overflow boundaries and rd=0.
        run_op("mul rd0", mk_md(5'd0, 1'b0), 32'h8000_0000, 32'd1,
               32'h8000_0000, 5'd0, mk_md(5'd0, 1'b0));
        tick();
        run_op("mul -2^31 fits", mk_md(5'd7, 1'b0), 32'h0001_0000, 32'hFFFF_8000,
               32'h8000_0000, 5'd7, mk_md(5'd7, 1'b0));
        tick();
        run_op("mul +2^31 ovf", mk_md(5'd7, 1'b0), 32'h0001_0000, 32'h0000_8000,
               32'd4, 5'd30, 32'hA800_0004);
        tick();
        run_op("mul -3*-5", mk_md(5'd31, 1'b0), 32'hFFFF_FFFD, 32'hFFFF_FFFB,
               32'd15, 5'd31, mk_md(5'd31, 1'b0));
        tick();

        // flush in IDLE blocks acceptance.
        x_instruction = mk_md(5'd4, 1'b0);
        x_opA         = 32'd1;
        x_opB         = 32'd1;
        flush         = 1'b1;
        #1;
        check("idle flush busy", 32'(busy), 32'd0);
        tick();
        flush         = 1'b0;
        x_instruction = 32'd0;
        #1;
        check("idle flush no accept", 32'(busy), 32'd0);
        tick();

        // flush at RUN count=10.
        x_instruction = mk_md(5'd8, 1'b0);
        x_opA         = 32'd2;
        x_opB         = 32'd3;
        #1;
        check("flush op accept", 32'(busy), 32'd1);
        for (int c = 1; c <= 11; c++) tick();
        check("flush op running", 32'(busy), 32'd1);
        flush         = 1'b1;
        x_instruction = 32'd0;
        tick();
        flush = 1'b0;
        #1;
        check("busy after flush", 32'(busy), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (result_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("no ready after flush", 32'(bad), 32'd0);
        check("flush hold data", result_data, 32'd15);
        check("flush hold reg", 32'(result_reg), 32'd31);
        check("flush hold wb", wb_instruction, mk_md(5'd31, 1'b0));

        // reset at RUN count=20.
        x_instruction = mk_md(5'd8, 1'b1);
        x_opA         = 32'd50;
        x_opB         = 32'd5;
        #1;
        check("reset op accept", 32'(busy), 32'd1);
        for (int c = 1; c <= 21; c++) tick();
        reset         = 1'b1;
        x_instruction = 32'd0;
        tick();
        reset = 1'b0;
        #1;
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset data", result_data, 32'd0);
        check("midrun reset reg", 32'(result_reg), 32'd0);
        check("midrun reset wb", wb_instruction, 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 35; c++) begin
            tick();
            if (result_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("no ready after reset", 32'(bad), 32'd0);

        run_op("div 50/5", mk_md(5'd2, 1'b1), 32'd50, 32'd5,
               32'd10, 5'd2, mk_md(5'd2, 1'b1));
        tick();
        x_instruction = 32'd0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
